// File: rtl/ext_intr_conditioner.sv
// rtl/ext_intr_conditioner.sv - sync, polarity, debounce and mask stage ahead of the PLIC
module ext_intr_conditioner #(
    parameter int NUM_SRC    = 8,
    parameter int FILTER_CNT = 4,
    parameter int CNT_W      = $clog2(FILTER_CNT + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] intr_i,
    input  logic [NUM_SRC-1:0] invert_i,
    input  logic [NUM_SRC-1:0] en_i,
    input  logic [NUM_SRC-1:0] clear_i,
    output logic [NUM_SRC-1:0] intr_o,
    output logic [NUM_SRC-1:0] rise_o,
    output logic [NUM_SRC-1:0] pending_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CNT - 1);

    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;
    logic [NUM_SRC-1:0] cond;
    logic [NUM_SRC-1:0] stable;
    logic [NUM_SRC-1:0] stable_next;
    logic [NUM_SRC-1:0] rise_next;
    logic [NUM_SRC-1:0] pending_next;
    logic [CNT_W-1:0]   cnt      [NUM_SRC];
    logic [CNT_W-1:0]   cnt_next [NUM_SRC];

    // Any return to agreement restarts the count, so separate glitches never add up.
    always_comb begin
        cond = sync2 ^ invert_i;
        for (int i = 0; i < NUM_SRC; i++) begin
            stable_next[i] = stable[i];
            cnt_next[i]    = '0;
            if (cond[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    stable_next[i] = cond[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
        rise_next    = stable_next & ~stable & en_i;
        pending_next = (pending_o & ~clear_i) | rise_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1     <= '0;
            sync2     <= '0;
            stable    <= '0;
            rise_o    <= '0;
            pending_o <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1     <= intr_i;
            sync2     <= sync1;
            stable    <= stable_next;
            rise_o    <= rise_next;
            pending_o <= pending_next;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Masking is combinational so enabling exposes the current level without delay.
    assign intr_o = stable & en_i;

endmodule

// File: tb/tb_ext_intr_conditioner.sv
// tb/tb_ext_intr_conditioner.sv - scoreboard bench for ext_intr_conditioner
module tb_ext_intr_conditioner;

    typedef struct {
        logic       rst;
        logic [7:0] intr;
        logic [7:0] invert;
        logic [7:0] en;
        logic [7:0] clear;
        logic [7:0] exp_intr;
        logic [7:0] exp_rise;
        logic [7:0] exp_pend;
        logic       chk1;
        logic [7:0] exp_intr1;
        logic [7:0] exp_rise1;
        logic [7:0] exp_pend1;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] intr_i = '0;
    logic [7:0] invert_i = '0;
    logic [7:0] en_i = '0;
    logic [7:0] clear_i = '0;
    logic [7:0] intr_o, rise_o, pending_o;
    logic [7:0] intr1, rise1, pend1;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl [36];
    vec_t hand [15];
    vec_t sb [$];

    ext_intr_conditioner #(.NUM_SRC(8), .FILTER_CNT(4)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .intr_i(intr_i), .invert_i(invert_i),
        .en_i(en_i), .clear_i(clear_i), .intr_o(intr_o), .rise_o(rise_o),
        .pending_o(pending_o)
    );

    ext_intr_conditioner #(.NUM_SRC(8), .FILTER_CNT(1)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .intr_i(intr_i), .invert_i(invert_i),
        .en_i(en_i), .clear_i(clear_i), .intr_o(intr1), .rise_o(rise1),
        .pending_o(pend1)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input int row, input logic [7:0] act,
                         input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %b want %b", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk_i);
        rst_i    = v.rst;
        intr_i   = v.intr;
        invert_i = v.invert;
        en_i     = v.en;
        clear_i  = v.clear;
        sb.push_back(v);
    endtask

    task automatic collect(input string tag, input int row);
        vec_t e;
        @(posedge clk_i);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_sb row %0d: got empty want entry", tag, row);
        end else begin
            e = sb.pop_front();
            check({tag, "_intr"}, row, intr_o, e.exp_intr);
            check({tag, "_rise"}, row, rise_o, e.exp_rise);
            check({tag, "_pend"}, row, pending_o, e.exp_pend);
            if (e.chk1) begin
                check({tag, "_intr_f1"}, row, intr1, e.exp_intr1);
                check({tag, "_rise_f1"}, row, rise1, e.exp_rise1);
                check({tag, "_pend_f1"}, row, pend1, e.exp_pend1);
            end
        end
    endtask

    initial begin
        vec_t v;
        // Sources: 0 plain/level+clear, 1 glitch then 4-cycle pulse, 2 inverted, 3 masked.
        for (int n = 0; n < 36; n++) begin
            v = '{default: '0};
            v.rst       = (n == 0);
            v.invert    = 8'b0000_0100;
            v.en        = (n >= 9) ? 8'hFF : 8'hF7;
            if (n > 0) begin
                v.intr[0]  = (n <= 19) || (n >= 26);
                v.intr[1]  = (n <= 3) || (n >= 10 && n <= 13);
                v.intr[2]  = (n >= 20);
                v.intr[3]  = 1'b1;
                v.clear[0] = (n == 31) || (n == 33);
                v.clear[2] = (n == 8);
                v.exp_intr[0] = (n >= 6 && n <= 24) || (n >= 31);
                v.exp_intr[1] = (n >= 15 && n <= 18);
                v.exp_intr[2] = (n >= 4 && n <= 24);
                v.exp_intr[3] = (n >= 9);
                v.exp_rise[0] = (n == 6) || (n == 31);
                v.exp_rise[1] = (n == 15);
                v.exp_rise[2] = (n == 4);
                v.exp_pend[0] = (n >= 6 && n < 33);
                v.exp_pend[1] = (n >= 15);
                v.exp_pend[2] = (n >= 4 && n < 8);
            end
            tbl[n] = v;
        end

        // Reset pulse mid-filter; the FILTER_CNT=1 instance checks the short-latency case.
        for (int h = 0; h < 15; h++) begin
            v = '{default: '0};
            v.rst     = (h == 0) || (h == 4);
            v.en      = 8'hFF;
            v.intr[0] = (h >= 1);
            v.chk1    = 1'b1;
            v.exp_intr[0]  = (h >= 10);
            v.exp_rise[0]  = (h == 10);
            v.exp_pend[0]  = (h >= 10);
            v.exp_intr1[0] = (h == 3) || (h >= 7);
            v.exp_rise1[0] = (h == 3) || (h == 7);
            v.exp_pend1[0] = (h == 3) || (h >= 7);
            hand[h] = v;
        end

        for (int n = 0; n < 36; n++) begin
            drive(tbl[n]);
            collect("tbl", n);
        end
        for (int h = 0; h < 15; h++) begin
            drive(hand[h]);
            collect("rst", h);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
